// File: rtl/mem_access_pkg.sv
`default_nettype none
// ============================================================================
// Module      : mem_access_pkg
// Description : Shared definitions for the MEM-stage load/store initiator:
//               operation codes, op-field bit positions, access sizes, the
//               FSM state encoding, the default RAM depth and an op-code
//               legality helper.
// Revision    : 1.0 - initial release
// ============================================================================
package mem_access_pkg;

   // Op-field layout: bit3 = store, bit2 = unsigned, bits[1:0] = size
   localparam int OP_STORE_BIT    = 3;
   localparam int OP_UNSIGNED_BIT = 2;

   localparam logic [1:0] SIZE_BYTE = 2'd0;
   localparam logic [1:0] SIZE_HALF = 2'd1;
   localparam logic [1:0] SIZE_WORD = 2'd2;

   localparam logic [3:0] OP_LB  = 4'h0;
   localparam logic [3:0] OP_LH  = 4'h1;
   localparam logic [3:0] OP_LW  = 4'h2;
   localparam logic [3:0] OP_LBU = 4'h4;
   localparam logic [3:0] OP_LHU = 4'h5;
   localparam logic [3:0] OP_SB  = 4'h8;
   localparam logic [3:0] OP_SH  = 4'h9;
   localparam logic [3:0] OP_SW  = 4'hA;

   localparam int DEFAULT_DEPTH_WORDS = 3072;

   typedef enum logic [1:0] {
      ST_IDLE   = 2'd0,
      ST_ACCESS = 2'd1,
      ST_RESP   = 2'd2
   } state_t;

   function automatic logic op_is_legal(input logic [3:0] op);
      logic legal;
      case (op)
         OP_LB, OP_LH, OP_LW, OP_LBU, OP_LHU,
         OP_SB, OP_SH, OP_SW: legal = 1'b1;
         default:             legal = 1'b0;
      endcase
      return legal;
   endfunction

endpackage
`default_nettype wire

// File: rtl/mem_lane_align.sv
`default_nettype none
// ============================================================================
// Module      : mem_lane_align
// Description : Combinational byte-lane logic. Builds byte enables and
//               replicated write data for stores, and extracts plus sign- or
//               zero-extends the addressed lane of read data for loads.
// Ports       : op        - latched operation code
//               addr_lo   - byte offset within the word (addr[1:0])
//               wdata     - right-justified store data
//               rdata     - RAM read data
//               be        - byte enables for the access size/offset
//               wdata_rep - store data replicated across all lanes
//               load_data - extended load result
// Revision    : 1.0 - initial release
// ============================================================================
module mem_lane_align
   import mem_access_pkg::*;
(
   input  logic [3:0]  op,
   input  logic [1:0]  addr_lo,
   input  logic [31:0] wdata,
   input  logic [31:0] rdata,
   output logic [3:0]  be,
   output logic [31:0] wdata_rep,
   output logic [31:0] load_data
);

   logic [7:0]  byte_lane;
   logic [15:0] half_lane;
   logic        is_unsigned;

   assign is_unsigned = op[OP_UNSIGNED_BIT];
   assign byte_lane   = rdata[8*addr_lo +: 8];
   assign half_lane   = rdata[16*addr_lo[1] +: 16];

   always_comb begin
      be        = 4'b1111;
      wdata_rep = wdata;
      load_data = rdata;
      case (op[1:0])
         SIZE_BYTE: begin
            be        = 4'b0001 << addr_lo;
            wdata_rep = {4{wdata[7:0]}};
            load_data = is_unsigned ? {24'h0, byte_lane}
                                    : {{24{byte_lane[7]}}, byte_lane};
         end
         SIZE_HALF: begin
            be        = addr_lo[1] ? 4'b1100 : 4'b0011;
            wdata_rep = {2{wdata[15:0]}};
            load_data = is_unsigned ? {16'h0, half_lane}
                                    : {{16{half_lane[15]}}, half_lane};
         end
         default: begin
            be        = 4'b1111;
            wdata_rep = wdata;
            load_data = rdata;
         end
      endcase
   end

endmodule
`default_nettype wire

// File: rtl/mem_access_unit.sv
`default_nettype none
// ============================================================================
// Module      : mem_access_unit
// Description : MEM-stage load/store initiator for the data RAM port. Takes
//               one request at a time (IDLE -> ACCESS -> RESP), drives the
//               word-addressed byte-enabled RAM for one cycle, checks for
//               misaligned / out-of-range / illegal accesses and returns a
//               registered response under valid/ready.
// Ports       : clk, rst_n                 - clock, async active-low reset
//               req_valid/req_ready        - request handshake
//               req_op/addr/wdata/rd       - request payload
//               flush                      - pipeline kill
//               rsp_valid/rsp_ready        - response handshake
//               rsp_data/rd/err/badaddr    - response payload
//               mem_addr/we/be/wdata/rdata - RAM port (combinational read)
// Revision    : 1.0 - initial release
// ============================================================================
module mem_access_unit
   import mem_access_pkg::*;
#(
   parameter int ADDR_W      = 14,
   parameter int DEPTH_WORDS = DEFAULT_DEPTH_WORDS
)(
   input  logic              clk,
   input  logic              rst_n,
   input  logic              req_valid,
   output logic              req_ready,
   input  logic [3:0]        req_op,
   input  logic [31:0]       req_addr,
   input  logic [31:0]       req_wdata,
   input  logic [4:0]        req_rd,
   input  logic              flush,
   output logic              rsp_valid,
   input  logic              rsp_ready,
   output logic [31:0]       rsp_data,
   output logic [4:0]        rsp_rd,
   output logic              rsp_err,
   output logic [31:0]       rsp_badaddr,
   output logic [ADDR_W-3:0] mem_addr,
   output logic              mem_we,
   output logic [3:0]        mem_be,
   output logic [31:0]       mem_wdata,
   input  logic [31:0]       mem_rdata
);

   state_t      state, state_nxt;

   logic [3:0]  held_op;
   logic [31:0] held_addr;
   logic [31:0] held_wdata;
   logic [4:0]  held_rd;

   logic [3:0]  lane_be;
   logic [31:0] lane_wdata;
   logic [31:0] lane_load;

   logic        op_illegal;
   logic        misaligned;
   logic        out_of_range;
   logic        access_err;
   logic        is_store;
   logic        in_access;
   logic [31:0] word_idx;

   mem_lane_align u_lane_align (
      .op        (held_op),
      .addr_lo   (held_addr[1:0]),
      .wdata     (held_wdata),
      .rdata     (mem_rdata),
      .be        (lane_be),
      .wdata_rep (lane_wdata),
      .load_data (lane_load)
   );

   // ---------------- error check on the latched request -------------------
   assign op_illegal   = !op_is_legal(held_op);
   assign misaligned   = ((held_op[1:0] == SIZE_HALF) && held_addr[0]) ||
                         ((held_op[1:0] == SIZE_WORD) && (held_addr[1:0] != 2'b00));
   assign word_idx     = 32'(held_addr[ADDR_W-1:2]);
   assign out_of_range = (held_addr[31:ADDR_W] != '0) ||
                         (word_idx >= $unsigned(DEPTH_WORDS));
   assign access_err   = op_illegal || misaligned || out_of_range;
   // Illegal codes behave as loads, so they can never write
   assign is_store     = held_op[OP_STORE_BIT] && !op_illegal;
   assign in_access    = (state == ST_ACCESS);

   // ---------------- RAM port ---------------------------------------------
   // Address and data come straight from the request latch, so they hold the
   // last request's values outside ACCESS and read 0 after reset.
   assign mem_addr  = held_addr[ADDR_W-1:2];
   assign mem_wdata = lane_wdata;
   assign mem_be    = (in_access && !access_err) ? lane_be : 4'b0000;
   // Flush and reset both kill the write without waiting for a clock edge
   assign mem_we    = in_access && is_store && !access_err && !flush;

   assign req_ready = (state == ST_IDLE) && !flush;
   assign rsp_valid = (state == ST_RESP);

   // ---------------- FSM ---------------------------------------------------
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) state <= ST_IDLE;
      else        state <= state_nxt;
   end

   always_comb begin
      state_nxt = state;
      case (state)
         ST_IDLE:   if (req_valid && !flush) state_nxt = ST_ACCESS;
         ST_ACCESS: state_nxt = flush ? ST_IDLE : ST_RESP;
         ST_RESP:   if (flush || rsp_ready) state_nxt = ST_IDLE;
         default:   state_nxt = ST_IDLE;
      endcase
   end

   // ---------------- request latch ----------------------------------------
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         held_op    <= 4'h0;
         held_addr  <= 32'h0;
         held_wdata <= 32'h0;
         held_rd    <= 5'h0;
      end else if (req_valid && req_ready) begin
         held_op    <= req_op;
         held_addr  <= req_addr;
         held_wdata <= req_wdata;
         held_rd    <= req_rd;
      end
   end

   // ---------------- response register ------------------------------------
   // Loaded only at the end of a non-flushed ACCESS; stable through RESP.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         rsp_data    <= 32'h0;
         rsp_rd      <= 5'h0;
         rsp_err     <= 1'b0;
         rsp_badaddr <= 32'h0;
      end else if (in_access && !flush) begin
         rsp_data    <= (access_err || is_store) ? 32'h0 : lane_load;
         rsp_rd      <= held_rd;
         rsp_err     <= access_err;
         rsp_badaddr <= access_err ? held_addr : 32'h0;
      end
   end

endmodule
`default_nettype wire
